signed_number_32_bit_seq_multiplier: RTL and testbench



---
 rtl/signed_number_32_bit_seq_multiplier_if.sv | 20 ++
 rtl/signed_number_32_bit_seq_multiplier.sv | 112 +++++++++++
 tb/tb_signed_number_32_bit_seq_multiplier.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/signed_number_32_bit_seq_multiplier_if.sv
// Handshake and operand/result bundle for the sequential signed 32x32 multiplier.
interface signed_number_32_bit_seq_multiplier_if;
    logic        start;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic        busy;
    logic        done;
    logic [63:0] product;
    logic        overflow32;

    modport master (
        output start, multiplicand, multiplier,
        input  busy, done, product, overflow32
    );

    modport slave (
        input  start, multiplicand, multiplier,
        output busy, done, product, overflow32
    );
endinterface

// File: rtl/signed_number_32_bit_seq_multiplier.sv
// Signed 32x32->64 multiplier: sign-magnitude conversion, 32-clock radix-2
// shift-add on the magnitudes, then a single re-sign cycle.
module signed_number_32_bit_seq_multiplier (
    input  logic clk,
    input  logic rst_n,
    signed_number_32_bit_seq_multiplier_if.slave m
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        SIGN
    } state_t;

    state_t      state, state_nx;
    logic        sign_r, sign_nx;
    logic [31:0] mcand_mag, mcand_nx;
    logic [31:0] mplr_reg, mplr_nx;
    logic [32:0] acc, acc_nx;
    logic [4:0]  cnt, cnt_nx;
    logic [63:0] product_r, product_nx;
    logic        ovf_r, ovf_nx;
    logic        done_r, done_nx;
    logic        busy_r, busy_nx;

    logic [32:0] sum;
    logic [63:0] mag;
    logic [63:0] signed_p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sign_r    <= 1'b0;
            mcand_mag <= '0;
            mplr_reg  <= '0;
            acc       <= '0;
            cnt       <= '0;
            product_r <= '0;
            ovf_r     <= 1'b0;
            done_r    <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state     <= state_nx;
            sign_r    <= sign_nx;
            mcand_mag <= mcand_nx;
            mplr_reg  <= mplr_nx;
            acc       <= acc_nx;
            cnt       <= cnt_nx;
            product_r <= product_nx;
            ovf_r     <= ovf_nx;
            done_r    <= done_nx;
            busy_r    <= busy_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        sign_nx    = sign_r;
        mcand_nx   = mcand_mag;
        mplr_nx    = mplr_reg;
        acc_nx     = acc;
        cnt_nx     = cnt;
        product_nx = product_r;
        ovf_nx     = ovf_r;
        done_nx    = 1'b0;
        busy_nx    = busy_r;

        sum      = acc + (mplr_reg[0] ? {1'b0, mcand_mag} : 33'd0);
        mag      = {acc[31:0], mplr_reg};
        signed_p = sign_r ? (64'd0 - mag) : mag;

        case (state)
            IDLE: begin
                if (m.start) begin
                    sign_nx  = m.multiplicand[31] ^ m.multiplier[31];
                    // Two's-complement negate; -2^31 maps onto itself, which is
                    // exactly its unsigned magnitude 0x8000_0000.
                    mcand_nx = m.multiplicand[31] ? (32'd0 - m.multiplicand) : m.multiplicand;
                    mplr_nx  = m.multiplier[31] ? (32'd0 - m.multiplier) : m.multiplier;
                    acc_nx   = '0;
                    cnt_nx   = '0;
                    busy_nx  = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                acc_nx  = {1'b0, sum[32:1]};
                mplr_nx = {sum[0], mplr_reg[31:1]};
                cnt_nx  = cnt + 5'd1;
                if (cnt == 5'd31) begin
                    state_nx = SIGN;
                end
            end
            SIGN: begin
                product_nx = signed_p;
                ovf_nx     = ~((&signed_p[63:31]) | ~(|signed_p[63:31]));
                done_nx    = 1'b1;
                busy_nx    = 1'b0;
                state_nx   = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign m.busy       = busy_r;
    assign m.done       = done_r;
    assign m.product    = product_r;
    assign m.overflow32 = ovf_r;

endmodule

// File: tb/tb_signed_number_32_bit_seq_multiplier.sv
// Self-checking bench: directed scenarios plus random operands against a
// 64-bit signed arithmetic reference.
module tb_signed_number_32_bit_seq_multiplier;

    logic clk;
    logic rst_n;
    int   passed;
    int   total;

    signed_number_32_bit_seq_multiplier_if mif ();

    signed_number_32_bit_seq_multiplier dut (
        .clk   (clk),
        .rst_n (rst_n),
        .m     (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ref_product(input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
    endfunction

    function automatic logic ref_ovf(input logic [63:0] p);
        longint sp;
        sp = $signed(p);
        return (sp > 64'sd2147483647) || (sp < -64'sd2147483648);
    endfunction

    // Stimulus only: issues one operation and measures latency/busy cycles.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         output logic [63:0] p, output logic ovf,
                         output int lat, output int busy_cycles);
        @(posedge clk); #1;
        mif.start        = 1'b1;
        mif.multiplicand = a;
        mif.multiplier   = b;
        @(posedge clk); #1;
        mif.start        = 1'b0;
        mif.multiplicand = $urandom;
        mif.multiplier   = $urandom;
        lat         = -1;
        busy_cycles = mif.busy ? 1 : 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (mif.done) begin
                lat = i;
                break;
            end
            if (mif.busy) busy_cycles++;
        end
        p   = mif.product;
        ovf = mif.overflow32;
    endtask

    task automatic test_reset();
        total++; if (mif.busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", mif.busy); else passed++;
        total++; if (mif.done !== 1'b0) $display("FAIL reset_done got=%b exp=0", mif.done); else passed++;
        total++; if (mif.product !== 64'd0) $display("FAIL reset_product got=%h exp=0", mif.product); else passed++;
        total++; if (mif.overflow32 !== 1'b0) $display("FAIL reset_ovf got=%b exp=0", mif.overflow32); else passed++;
    endtask

    task automatic test_basic();
        logic [63:0] p;
        logic        o;
        int          lat, bc;
        do_op(32'd7, -32'sd3, p, o, lat, bc);
        total++; if (lat !== 33) $display("FAIL basic_latency got=%0d exp=33", lat); else passed++;
        total++; if (bc !== 33) $display("FAIL basic_busy_cycles got=%0d exp=33", bc); else passed++;
        total++; if (mif.busy !== 1'b0) $display("FAIL basic_busy_at_done got=%b exp=0", mif.busy); else passed++;
        total++; if (p !== 64'hFFFF_FFFF_FFFF_FFEB) $display("FAIL basic_product got=%h exp=ffffffffffffffeb", p); else passed++;
        total++; if (o !== 1'b0) $display("FAIL basic_ovf got=%b exp=0", o); else passed++;
        @(posedge clk); #1;
        total++; if (mif.done !== 1'b0) $display("FAIL basic_done_pulse got=%b exp=0", mif.done); else passed++;
        total++; if (mif.product !== 64'hFFFF_FFFF_FFFF_FFEB) $display("FAIL basic_product_hold got=%h", mif.product); else passed++;
    endtask

    task automatic test_edges();
        logic [31:0] ta [4];
        logic [31:0] tb [4];
        logic [63:0] tp [4];
        logic        to [4];
        logic [63:0] p;
        logic        o;
        int          lat, bc;
        ta[0] = 32'h8000_0000; tb[0] = 32'h8000_0000; tp[0] = 64'h4000_0000_0000_0000; to[0] = 1'b1;
        ta[1] = 32'h7FFF_FFFF; tb[1] = 32'h7FFF_FFFF; tp[1] = 64'h3FFF_FFFF_0000_0001; to[1] = 1'b1;
        ta[2] = 32'd0;         tb[2] = -32'sd5;       tp[2] = 64'd0;                  to[2] = 1'b0;
        ta[3] = 32'h8000_0000; tb[3] = 32'd1;         tp[3] = 64'hFFFF_FFFF_8000_0000; to[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            do_op(ta[i], tb[i], p, o, lat, bc);
            total++; if (lat !== 33) $display("FAIL edge%0d_latency got=%0d exp=33", i, lat); else passed++;
            total++; if (p !== tp[i]) $display("FAIL edge%0d_product got=%h exp=%h", i, p, tp[i]); else passed++;
            total++; if (o !== to[i]) $display("FAIL edge%0d_ovf got=%b exp=%b", i, o, to[i]); else passed++;
        end
    endtask

    task automatic test_ignore_start();
        int lat;
        @(posedge clk); #1;
        mif.start = 1'b1; mif.multiplicand = 32'd100; mif.multiplier = 32'd200;
        @(posedge clk); #1;
        mif.start = 1'b0;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            mif.start = (i == 10);
            if (i == 10) begin
                mif.multiplicand = 32'd9; mif.multiplier = 32'd9;
            end
            if (mif.done) begin
                lat = i;
                break;
            end
        end
        mif.start = 1'b0;
        total++; if (lat !== 33) $display("FAIL ignore_latency got=%0d exp=33", lat); else passed++;
        total++; if (mif.product !== 64'd20000) $display("FAIL ignore_product got=%0d exp=20000", mif.product); else passed++;
        @(posedge clk); #1;
        total++; if (mif.busy !== 1'b0) $display("FAIL ignore_no_restart got=%b exp=0", mif.busy); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [63:0] p;
        logic        o;
        int          lat, bc;
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, p, o, lat, bc);
        total++; if (p !== 64'd1) $display("FAIL b2b_first_product got=%h exp=1", p); else passed++;
        // Still in the done cycle: request the next operation now.
        mif.start = 1'b1; mif.multiplicand = 32'hFFFF_FFFF; mif.multiplier = 32'd1;
        @(posedge clk); #1;
        mif.start = 1'b0;
        total++; if (mif.busy !== 1'b1) $display("FAIL b2b_accept got=%b exp=1", mif.busy); else passed++;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (i == 20 && mif.product !== 64'd1) begin
                total++; $display("FAIL b2b_hold_while_busy got=%h exp=1", mif.product);
            end
            if (mif.done) begin
                lat = i;
                break;
            end
        end
        total++; if (lat !== 33) $display("FAIL b2b_second_latency got=%0d exp=33", lat); else passed++;
        total++; if (mif.product !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL b2b_second_product got=%h exp=ffffffffffffffff", mif.product); else passed++;
    endtask

    task automatic test_reset_mid();
        int spurious;
        @(posedge clk); #1;
        mif.start = 1'b1; mif.multiplicand = 32'd12345; mif.multiplier = 32'd678;
        @(posedge clk); #1;
        mif.start = 1'b0;
        repeat (15) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        total++; if (mif.busy !== 1'b0) $display("FAIL rstmid_busy got=%b exp=0", mif.busy); else passed++;
        total++; if (mif.done !== 1'b0) $display("FAIL rstmid_done got=%b exp=0", mif.done); else passed++;
        total++; if (mif.product !== 64'd0) $display("FAIL rstmid_product got=%h exp=0", mif.product); else passed++;
        total++; if (mif.overflow32 !== 1'b0) $display("FAIL rstmid_ovf got=%b exp=0", mif.overflow32); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        spurious = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (mif.done || mif.busy) spurious++;
        end
        total++; if (spurious !== 0) $display("FAIL rstmid_no_done got=%0d exp=0", spurious); else passed++;
    endtask

    task automatic test_random(input int n);
        logic [31:0] a, b, pick [5];
        logic [63:0] p, e;
        logic        o;
        int          lat, bc, errs;
        pick[0] = 32'd0; pick[1] = 32'd1; pick[2] = 32'hFFFF_FFFF;
        pick[3] = 32'h8000_0000; pick[4] = 32'h7FFF_FFFF;
        errs = 0;
        for (int i = 0; i < n; i++) begin
            a = ($urandom_range(0, 7) == 0) ? pick[$urandom_range(0, 4)] : $urandom;
            b = ($urandom_range(0, 7) == 0) ? pick[$urandom_range(0, 4)] : $urandom;
            if ($urandom_range(0, 3) == 0) a = a >>> $urandom_range(0, 31);
            do_op(a, b, p, o, lat, bc);
            e = ref_product(a, b);
            total++;
            if (lat !== 33 || p !== e || o !== ref_ovf(e)) begin
                if (errs < 20)
                    $display("FAIL random a=%h b=%h got=%h/%b lat=%0d exp=%h/%b lat=33",
                             a, b, p, o, lat, e, ref_ovf(e));
                errs++;
            end else passed++;
        end
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst_n  = 1'b0;
        mif.start = 1'b0;
        mif.multiplicand = '0;
        mif.multiplier   = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        test_basic();
        test_edges();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_random(1500);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
